// File: rtl/lcd_pkg.sv
// Definitions shared by the QC12864B (ST7920) 8-bit parallel bus reader and writer:
// command codes, the bus FSM states and the default 50 MHz timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        CMD_RD_STAT = 2'b00,
        CMD_RD_DATA = 2'b01,
        CMD_WAIT    = 2'b10,
        CMD_ILLEGAL = 2'b11
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } lcd_state_e;

    // Bus timing in 50 MHz clock cycles.
    localparam int unsigned LCD_T_AS      = 2;
    localparam int unsigned LCD_T_PW      = 16;
    localparam int unsigned LCD_T_H       = 2;
    localparam int unsigned LCD_T_GAP     = 40;
    localparam int unsigned LCD_MAX_POLLS = 1000;

    // Counter width able to hold the largest (duration - 1) load value.
    function automatic int unsigned tick_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lcd_tick_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_tick_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/st7920_bus_reader.sv
// Read-side bus master for the ST7920 in 8-bit parallel mode: status reads, data reads
// and a polled wait-until-not-busy. Control pins are muxed with the writer via bus_own.
module st7920_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS      = LCD_T_AS,
    parameter int unsigned T_PW      = LCD_T_PW,
    parameter int unsigned T_H       = LCD_T_H,
    parameter int unsigned T_GAP     = LCD_T_GAP,
    parameter int unsigned MAX_POLLS = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] cmd,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout,
    output logic       bus_own,
    output logic       RS,
    output logic       RW,
    output logic       EN,
    output logic       PSB,
    input  logic [7:0] DB
);

    localparam int unsigned CW = tick_width(T_AS, T_PW, T_H, T_GAP);
    localparam int unsigned PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    if (T_AS == 0 || T_PW == 0 || T_H == 0 || T_GAP == 0 || MAX_POLLS == 0) begin : g_bad_param
        $error("st7920_bus_reader: timing and poll parameters must be non-zero");
    end

    lcd_state_e     state_q, state_d;
    lcd_cmd_e       op_q, op_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic           repoll_q, repoll_d;
    logic           illegal_q, illegal_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           busy_q, busy_d;
    logic [6:0]     ac_q, ac_d;
    logic           timeout_q, timeout_d;
    logic           tick_load, tick_done, accept;
    logic [CW-1:0]  tick_val;

    lcd_tick_cnt #(.W(CW)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tick_load),
        .load_val (tick_val),
        .done     (tick_done)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        poll_d    = poll_q;
        repoll_d  = repoll_q;
        illegal_d = 1'b0;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        ac_d      = ac_q;
        timeout_d = timeout_q;
        tick_load = 1'b0;
        tick_val  = '0;
        ready     = 1'b0;
        rd_valid  = illegal_q;

        unique case (state_q)
            IDLE: ready = 1'b1;
            SETUP: if (tick_done) begin
                state_d   = STROBE;
                tick_load = 1'b1;
                tick_val  = CW'(T_PW - 1);
            end
            STROBE: if (tick_done) begin
                state_d   = HOLD;
                tick_load = 1'b1;
                tick_val  = CW'(T_H - 1);
                rd_data_d = DB;
                if (op_q != CMD_RD_DATA) begin
                    busy_d = DB[7];
                    ac_d   = DB[6:0];
                end
                repoll_d = 1'b0;
                if (op_q == CMD_WAIT && DB[7]) begin
                    if (poll_q == POLL_LAST) timeout_d = 1'b1;
                    else                     repoll_d  = 1'b1;
                end
            end
            HOLD: if (tick_done) begin
                state_d   = GAP;
                tick_load = 1'b1;
                tick_val  = CW'(T_GAP - 1);
                rd_valid  = !repoll_q;
                if (repoll_q && poll_q != POLL_LAST) poll_d = poll_q + 1'b1;
            end
            GAP: if (tick_done) begin
                // A still-busy wait op loops straight back without releasing ready.
                if (repoll_q) begin
                    state_d   = SETUP;
                    tick_load = 1'b1;
                    tick_val  = CW'(T_AS - 1);
                end else begin
                    state_d = IDLE;
                    ready   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        accept = req && ready;
        if (accept) begin
            if (cmd == CMD_ILLEGAL) begin
                state_d   = IDLE;
                illegal_d = 1'b1;
                timeout_d = 1'b1;
            end else begin
                state_d   = SETUP;
                tick_load = 1'b1;
                tick_val  = CW'(T_AS - 1);
                op_d      = lcd_cmd_e'(cmd);
                poll_d    = '0;
                repoll_d  = 1'b0;
                timeout_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= CMD_RD_STAT;
            poll_q    <= '0;
            repoll_q  <= 1'b0;
            illegal_q <= 1'b0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            ac_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            poll_q    <= poll_d;
            repoll_q  <= repoll_d;
            illegal_q <= illegal_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            ac_q      <= ac_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus_own   = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign RW        = bus_own;
    assign RS        = bus_own && (op_q == CMD_RD_DATA);
    assign EN        = (state_q == STROBE);
    assign PSB       = 1'b1;
    assign rd_data   = rd_data_q;
    assign busy_flag = busy_q;
    assign addr_cnt  = ac_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_st7920_bus_reader.sv
// Directed bench for st7920_bus_reader: cycle-counted transactions with hand-computed
// expectations, run with MAX_POLLS=4 so the wait timeout is reachable.
module tb_st7920_bus_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [1:0] cmd_i = 2'b00;
    logic [7:0] db = 8'h00;
    logic       ready, rd_valid, busy_flag, timeout, bus_own, rs, rw, en, psb;
    logic [7:0] rd_data;
    logic [6:0] addr_cnt;

    int n_vec = 0;
    int n_err = 0;

    // per-transaction observations
    int m_en_cnt, m_en_first, m_en_last_rise, m_en_last, m_own_cnt, m_rs_bad;
    int m_vld_cnt, m_vld_cyc, m_rdy_cyc, m_to_c1;
    logic [7:0] m_data;
    logic       m_bf, m_to;
    logic [6:0] m_ac;

    always #5 clk = ~clk;

    st7920_bus_reader #(
        .T_AS(2), .T_PW(16), .T_H(2), .T_GAP(40), .MAX_POLLS(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .cmd       (cmd_i),
        .ready     (ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy_flag (busy_flag),
        .addr_cnt  (addr_cnt),
        .timeout   (timeout),
        .bus_own   (bus_own),
        .RS        (rs),
        .RW        (rw),
        .EN        (en),
        .PSB       (psb),
        .DB        (db)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts one op at a negedge-aligned req, then samples every cycle at negedge until
    // ready returns plus 25 cycles. A stray req is pulsed in cycle 30 while busy.
    task automatic run_op(input logic [1:0] c, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3, input int max_cyc);
        logic [7:0] seq [4];
        logic       en_prev;
        int         k, idx;
        seq[0] = d0; seq[1] = d1; seq[2] = d2; seq[3] = d3;
        m_en_cnt = 0; m_en_first = -1; m_en_last_rise = -1; m_en_last = -1;
        m_own_cnt = 0; m_rs_bad = 0; m_vld_cnt = 0; m_vld_cyc = -1; m_rdy_cyc = -1;
        m_to_c1 = -1; m_data = 8'h00; m_bf = 1'b0; m_ac = 7'h00; m_to = 1'b0;
        en_prev = 1'b0;
        @(negedge clk);
        db = d0;
        req = 1'b1;
        cmd_i = c;
        check_eq("ready_before_accept", 32'(ready), 32'd1);
        @(posedge clk);
        k = 0;
        while (k < max_cyc && (m_rdy_cyc < 0 || k < m_rdy_cyc + 25)) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req = 1'b0;
                cmd_i = c ^ 2'b01;
                m_to_c1 = int'(timeout);
            end
            if (en && !en_prev) begin
                m_en_cnt++;
                if (m_en_first < 0) m_en_first = k;
                m_en_last_rise = k;
            end
            en_prev = en;
            if (en) m_en_last = k;
            if (bus_own) begin
                m_own_cnt++;
                if (rs !== (c == 2'b01) || rw !== 1'b1) m_rs_bad++;
            end
            if (rd_valid) begin
                m_vld_cnt++;
                m_vld_cyc = k;
                m_data = rd_data;
                m_bf = busy_flag;
                m_ac = addr_cnt;
                m_to = timeout;
            end
            if (ready && m_rdy_cyc < 0) m_rdy_cyc = k;
            if (k == 30) begin
                req = 1'b1;
                cmd_i = 2'b00;
            end else begin
                req = 1'b0;
            end
            idx = (m_en_cnt == 0) ? 0 : ((m_en_cnt > 4) ? 3 : m_en_cnt - 1);
            db = seq[idx];
        end
        if (m_rdy_cyc < 0) check_eq("ready_never_returned", 32'd0, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vld_seen, en_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h00);
        check_eq("rst_busy_flag", 32'(busy_flag), 32'd0);
        check_eq("rst_addr_cnt", 32'(addr_cnt), 32'h00);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_bus_own", 32'(bus_own), 32'd0);
        check_eq("rst_rs_rw_en", {29'd0, rs, rw, en}, 32'd0);
        check_eq("rst_psb", 32'(psb), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Status read, BF=0, AC=1A
        run_op(2'b00, 8'h1A, 8'h1A, 8'h1A, 8'h1A, 200);
        check_eq("st_en_first", 32'(m_en_first), 32'd3);
        check_eq("st_en_last", 32'(m_en_last), 32'd18);
        check_eq("st_en_count", 32'(m_en_cnt), 32'd1);
        check_eq("st_own_cycles", 32'(m_own_cnt), 32'd20);
        check_eq("st_rs_rw", 32'(m_rs_bad), 32'd0);
        check_eq("st_vld_count", 32'(m_vld_cnt), 32'd1);
        check_eq("st_vld_cycle", 32'(m_vld_cyc), 32'd20);
        check_eq("st_rd_data", 32'(m_data), 32'h1A);
        check_eq("st_busy_flag", 32'(m_bf), 32'd0);
        check_eq("st_addr_cnt", 32'(m_ac), 32'h1A);
        check_eq("st_timeout", 32'(m_to), 32'd0);
        check_eq("st_ready_cycle", 32'(m_rdy_cyc), 32'd60);

        // Data read: RS=1, status registers untouched
        run_op(2'b01, 8'h41, 8'h41, 8'h41, 8'h41, 200);
        check_eq("dr_en_count", 32'(m_en_cnt), 32'd1);
        check_eq("dr_rs_rw", 32'(m_rs_bad), 32'd0);
        check_eq("dr_own_cycles", 32'(m_own_cnt), 32'd20);
        check_eq("dr_vld_cycle", 32'(m_vld_cyc), 32'd20);
        check_eq("dr_rd_data", 32'(m_data), 32'h41);
        check_eq("dr_busy_flag", 32'(m_bf), 32'd0);
        check_eq("dr_addr_cnt", 32'(m_ac), 32'h1A);
        check_eq("dr_ready_cycle", 32'(m_rdy_cyc), 32'd60);

        // Illegal command: immediate rd_valid with timeout, no bus activity
        @(negedge clk);
        req = 1'b1;
        cmd_i = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check_eq("il_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("il_timeout", 32'(timeout), 32'd1);
        check_eq("il_rd_data", 32'(rd_data), 32'h41);
        check_eq("il_ready", 32'(ready), 32'd1);
        vld_seen = 0;
        en_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_valid) vld_seen++;
            if (en || bus_own) en_seen++;
        end
        check_eq("il_no_repeat_vld", 32'(vld_seen), 32'd0);
        check_eq("il_no_bus", 32'(en_seen), 32'd0);

        // Wait op: busy for 3 polls then free with AC=05
        run_op(2'b10, 8'h80, 8'h80, 8'h80, 8'h05, 400);
        check_eq("wt_timeout_cleared", 32'(m_to_c1), 32'd0);
        check_eq("wt_en_count", 32'(m_en_cnt), 32'd4);
        check_eq("wt_en_first", 32'(m_en_first), 32'd3);
        check_eq("wt_en_last_rise", 32'(m_en_last_rise), 32'd183);
        check_eq("wt_own_cycles", 32'(m_own_cnt), 32'd80);
        check_eq("wt_vld_count", 32'(m_vld_cnt), 32'd1);
        check_eq("wt_vld_cycle", 32'(m_vld_cyc), 32'd200);
        check_eq("wt_busy_flag", 32'(m_bf), 32'd0);
        check_eq("wt_addr_cnt", 32'(m_ac), 32'h05);
        check_eq("wt_timeout", 32'(m_to), 32'd0);
        check_eq("wt_ready_cycle", 32'(m_rdy_cyc), 32'd240);

        // Wait op with DB stuck at FF: times out after MAX_POLLS=4 strobes
        run_op(2'b10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 400);
        check_eq("to_en_count", 32'(m_en_cnt), 32'd4);
        check_eq("to_vld_count", 32'(m_vld_cnt), 32'd1);
        check_eq("to_vld_cycle", 32'(m_vld_cyc), 32'd200);
        check_eq("to_timeout", 32'(m_to), 32'd1);
        check_eq("to_busy_flag", 32'(m_bf), 32'd1);
        check_eq("to_addr_cnt", 32'(m_ac), 32'h7F);
        check_eq("to_rd_data", 32'(m_data), 32'hFF);
        check_eq("to_ready_cycle", 32'(m_rdy_cyc), 32'd240);

        // Reset during STROBE
        @(negedge clk);
        db = 8'h3C;
        req = 1'b1;
        cmd_i = 2'b00;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        check_eq("mr_en_before_reset", 32'(en), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mr_en_dropped", 32'(en), 32'd0);
        check_eq("mr_bus_own_dropped", 32'(bus_own), 32'd0);
        check_eq("mr_no_vld", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mr_ready", 32'(ready), 32'd1);
        check_eq("mr_rd_data_cleared", 32'(rd_data), 32'h00);
        vld_seen = 0;
        en_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rd_valid) vld_seen++;
            if (en) en_seen++;
        end
        check_eq("mr_no_late_vld", 32'(vld_seen), 32'd0);
        check_eq("mr_no_late_en", 32'(en_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
